// File: rtl/inst_queue_param.sv
// inst_queue_param: IF2->ID1 instruction queue. Compacts sparse fetch groups into a circular buffer and issues the oldest entries in order.
// Optional macro IQ_BYPASS_EN: incoming slots pass straight to the outputs while the queue is empty.
module inst_queue_param #(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int AW      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           i_valid,
  input  logic [FETCH_W*AW-1:0]        i_pc,
  input  logic [FETCH_W*AW-1:0]        i_ir,
  input  logic [$clog2(ISSUE_W+1)-1:0] i_take,
  output logic [ISSUE_W*AW-1:0]        o_pc,
  output logic [ISSUE_W*AW-1:0]        o_ir,
  output logic [ISSUE_W-1:0]           o_valid,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [AW-1:0] pc_mem [DEPTH];
  logic [AW-1:0] ir_mem [DEPTH];

  logic [CW-1:0] slot_off [FETCH_W];
  logic [CW-1:0] wr_n, wr_cnt, avail, take_n;
  logic          wr_en, byp_act;

  // slot_off[k] is the position of incoming slot k inside the compacted group
  always_comb begin
    wr_n = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      slot_off[k] = wr_n;
      wr_n        = wr_n + CW'(i_valid[k]);
    end
  end

  assign wr_en  = !full_q && !flush;
  assign wr_cnt = wr_en ? wr_n : '0;

`ifdef IQ_BYPASS_EN
  assign byp_act = (count_q == '0) && wr_en;
`else
  assign byp_act = 1'b0;
`endif

  // Consumption is clamped to what is actually presented, so count never underflows
  always_comb begin
    if (byp_act)
      avail = (wr_cnt > CW'(ISSUE_W)) ? CW'(ISSUE_W) : wr_cnt;
    else
      avail = (count_q > CW'(ISSUE_W)) ? CW'(ISSUE_W) : count_q;
    take_n = (CW'(i_take) > avail) ? avail : CW'(i_take);
  end

  always_comb begin
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(take_n);
      tail_d  = tail_q + PW'(wr_cnt);
      count_d = count_q + wr_cnt - take_n;
    end
    full_d = (CW'(DEPTH) - count_d) < CW'(FETCH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // In bypass mode every accepted slot is still written; taken ones are skipped by head
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (i_valid[k]) begin
          pc_mem[tail_q + PW'(slot_off[k])] <= i_pc[k*AW +: AW];
          ir_mem[tail_q + PW'(slot_off[k])] <= i_ir[k*AW +: AW];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ISSUE_W; gi++) begin : g_issue
      logic [PW-1:0] rd_idx;
      logic          slot_vld;
      logic [AW-1:0] slot_pc, slot_ir;

      assign rd_idx = head_q + PW'(gi);
`ifdef IQ_BYPASS_EN
      logic          byp_vld;
      logic [AW-1:0] byp_pc, byp_ir;

      always_comb begin
        byp_vld = 1'b0;
        byp_pc  = '0;
        byp_ir  = '0;
        for (int k = 0; k < FETCH_W; k++) begin
          if (i_valid[k] && slot_off[k] == CW'(gi)) begin
            byp_vld = 1'b1;
            byp_pc  = i_pc[k*AW +: AW];
            byp_ir  = i_ir[k*AW +: AW];
          end
        end
      end

      assign slot_vld = byp_act ? byp_vld : (count_q > CW'(gi));
      assign slot_pc  = byp_act ? byp_pc  : pc_mem[rd_idx];
      assign slot_ir  = byp_act ? byp_ir  : ir_mem[rd_idx];
`else
      assign slot_vld = count_q > CW'(gi);
      assign slot_pc  = pc_mem[rd_idx];
      assign slot_ir  = ir_mem[rd_idx];
`endif
      assign o_valid[gi]        = slot_vld;
      assign o_pc[gi*AW +: AW]  = slot_vld ? slot_pc : '0;
      assign o_ir[gi*AW +: AW]  = slot_vld ? slot_ir : '0;
    end
  endgenerate

  assign o_full  = full_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_inst_queue_param.sv
// Self-checking bench for inst_queue_param: vector table plus scoreboard model of queue contents.
module tb_inst_queue_param;
  localparam int DEPTH   = 16;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int AW      = 32;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  i_valid;
  logic [63:0] i_pc, i_ir;
  logic [1:0]  i_take;
  logic [63:0] o_pc, o_ir;
  logic [1:0]  o_valid;
  logic        o_full;
  logic [4:0]  o_count;

  inst_queue_param #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_pc(i_pc), .i_ir(i_ir),
    .i_take(i_take), .o_pc(o_pc), .o_ir(o_ir), .o_valid(o_valid), .o_full(o_full),
    .o_count(o_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mq[$];
  logic        m_full = 1'b0;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] p0, p1;
    logic [1:0]  tk;
    logic        fl;
    int          exp_cnt;
    logic        exp_full;
    logic [1:0]  exp_v;
    logic [31:0] exp_pc0;
  } vec_t;
  vec_t vt[13];

  function automatic logic [31:0] ir_of(input logic [31:0] pc);
    return pc ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle: compare outputs against the model before the edge, then advance the model.
  task automatic step(input string tag, input logic [1:0] v, input logic [31:0] p0,
                      input logic [31:0] p1, input logic [1:0] tk, input logic fl);
    logic [31:0] inc[$];
    logic [31:0] show[$];
    logic [1:0]  exp_v;
    logic [31:0] ep;
    int          avail, tn;
    i_valid = v;
    i_pc    = {p1, p0};
    i_ir    = {ir_of(p1), ir_of(p0)};
    i_take  = tk;
    flush   = fl;
    if (!m_full && !fl) begin
      if (v[0]) inc.push_back(p0);
      if (v[1]) inc.push_back(p1);
    end
    show  = mq;
    avail = (mq.size() > ISSUE_W) ? ISSUE_W : mq.size();
`ifdef IQ_BYPASS_EN
    if (mq.size() == 0 && !fl && !m_full) begin
      show  = inc;
      avail = (inc.size() > ISSUE_W) ? ISSUE_W : inc.size();
    end
`endif
    #1;
    exp_v = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      exp_v[k] = (k < show.size());
      ep       = (k < show.size()) ? show[k] : 32'h0;
      check($sformatf("%s pc%0d", tag, k), 64'(o_pc[k*AW +: AW]), 64'(ep));
      check($sformatf("%s ir%0d", tag, k), 64'(o_ir[k*AW +: AW]),
            (k < show.size()) ? 64'(ir_of(ep)) : 64'h0);
    end
    check({tag, " valid"}, 64'(o_valid), 64'(exp_v));
    check({tag, " count"}, 64'(o_count), 64'(mq.size()));
    check({tag, " full"},  64'(o_full),  64'(m_full));
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      tn = (int'(tk) > avail) ? avail : int'(tk);
      foreach (inc[i]) mq.push_back(inc[i]);
      repeat (tn) void'(mq.pop_front());
    end
    m_full = (DEPTH - mq.size()) < FETCH_W;
    @(negedge clk);
    $display("[TB] %s v=%b take=%0d flush=%b -> count=%0d", tag, v, tk, fl, o_count);
  endtask

  task automatic idle();
    i_valid = '0;
    i_take  = '0;
    flush   = 1'b0;
  endtask

  initial begin
    logic [31:0] wp, ip;
    // vector table: expectations are the values visible after the edge
    vt[0] = '{2'b11, 32'h1c000000, 32'h1c000004, 2'd0, 1'b0, 2, 1'b0, 2'b11, 32'h1c000000};
    for (int i = 1; i < 8; i++)
      vt[i] = '{2'b11, 32'h1c000000 + 32'(8*i), 32'h1c000004 + 32'(8*i), 2'd0, 1'b0,
                2*(i+1), (i == 7), 2'b11, 32'h1c000000};
    vt[8]  = '{2'b11, 32'h1c0000f0, 32'h1c0000f4, 2'd0, 1'b0, 16, 1'b1, 2'b11, 32'h1c000000};
    vt[9]  = '{2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 14, 1'b0, 2'b11, 32'h1c000008};
    vt[10] = '{2'b00, 32'h0, 32'h0, 2'd0, 1'b1, 0, 1'b0, 2'b00, 32'h0};
    vt[11] = '{2'b10, 32'hdeadbeef, 32'h1c000040, 2'd0, 1'b0, 1, 1'b0, 2'b01, 32'h1c000040};
    vt[12] = '{2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 0, 1'b0, 2'b00, 32'h0};

    rst = 1'b1;
    idle();
    i_pc = '0;
    i_ir = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset valid", 64'(o_valid), 64'h0);
    check("reset count", 64'(o_count), 64'h0);
    check("reset full",  64'(o_full),  64'h0);
    check("reset pc",    o_pc,         64'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), vt[i].v, vt[i].p0, vt[i].p1, vt[i].tk, vt[i].fl);
      idle();
      #1;
      check($sformatf("vec%0d post count", i), 64'(o_count), 64'(vt[i].exp_cnt));
      check($sformatf("vec%0d post full", i),  64'(o_full),  64'(vt[i].exp_full));
      check($sformatf("vec%0d post valid", i), 64'(o_valid), 64'(vt[i].exp_v));
      check($sformatf("vec%0d post pc0", i),   64'(o_pc[31:0]), 64'(vt[i].exp_pc0));
    end

    // steady write-2/take-2 at occupancy 4: pointers wrap several times
    wp = 32'h1c001000;
    ip = wp;
    repeat (2) begin
      step("fill", 2'b11, wp, wp + 32'd4, 2'd0, 1'b0);
      wp = wp + 32'd8;
    end
    for (int c = 0; c < 40; c++) begin
      check($sformatf("stream%0d slot0", c), 64'(o_pc[31:0]),  64'(ip));
      check($sformatf("stream%0d slot1", c), 64'(o_pc[63:32]), 64'(ip + 32'd4));
      step("wrap", 2'b11, wp, wp + 32'd4, 2'd2, 1'b0);
      wp = wp + 32'd8;
      ip = ip + 32'd8;
    end
    check("wrap count", 64'(o_count), 64'd4);
    step("drain1", 2'b00, 32'h0, 32'h0, 2'd1, 1'b0);
    step("drain2", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    check("drain count", 64'(o_count), 64'd1);
    step("clamp", 2'b00, 32'h0, 32'h0, 2'd2, 1'b0);
    check("clamp count", 64'(o_count), 64'd0);
    check("clamp valid", 64'(o_valid), 64'd0);

    // flush overrides simultaneous write and take
    for (int i = 0; i < 3; i++)
      step("pre_flush", 2'b11, 32'h1c002000 + 32'(8*i), 32'h1c002004 + 32'(8*i), 2'd0, 1'b0);
    check("pre_flush count", 64'(o_count), 64'd6);
    step("flush", 2'b11, 32'h1c003000, 32'h1c003004, 2'd1, 1'b1);
    idle();
    #1;
    check("flush count", 64'(o_count), 64'd0);
    check("flush valid", 64'(o_valid), 64'd0);
    check("flush full",  64'(o_full),  64'd0);

    // empty queue, write 2 and take 1 in the same cycle
    i_valid = 2'b11;
    i_pc    = {32'h1c004004, 32'h1c004000};
    i_ir    = {ir_of(32'h1c004004), ir_of(32'h1c004000)};
    i_take  = 2'd1;
    #1;
`ifdef IQ_BYPASS_EN
    check("byp same-cycle valid", 64'(o_valid), 64'h3);
`else
    check("byp same-cycle valid", 64'(o_valid), 64'h0);
`endif
    step("byp", 2'b11, 32'h1c004000, 32'h1c004004, 2'd1, 1'b0);
    idle();
    #1;
`ifdef IQ_BYPASS_EN
    check("byp next count", 64'(o_count), 64'd1);
    check("byp next pc0", 64'(o_pc[31:0]), 64'h1c004004);
`else
    check("byp next count", 64'(o_count), 64'd2);
    check("byp next pc0", 64'(o_pc[31:0]), 64'h1c004000);
`endif

    // mid-operation reset discards everything
    step("pre_rst", 2'b11, 32'h1c005000, 32'h1c005004, 2'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_full = 1'b0;
    check("midrst count", 64'(o_count), 64'd0);
    check("midrst valid", 64'(o_valid), 64'd0);
    check("midrst pc",    o_pc,         64'd0);
    step("post_rst", 2'b01, 32'h1c006000, 32'h0, 2'd0, 1'b0);
    step("post_rst2", 2'b00, 32'h0, 32'h0, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
